// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous double buffering.
// Define SEG7_HEX_EN to decode nibbles 10-15 as A, b, C, d, E, F (otherwise they are dark).
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] val;
    logic [NUM_DIGITS-1:0]   blk;
    logic [NUM_DIGITS-1:0]   dpm;
  } disp_t;

  localparam disp_t DispReset = '{val: '0, blk: '1, dpm: '0};

  // Scan position
  logic [PreW-1:0] pre_q, pre_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pre_wrap;
  logic            frame_end;

  // Display buffers
  disp_t in_w;
  disp_t pend_q, pend_d;
  disp_t act_q, act_d;
  logic  pend_valid_q, pend_valid_d;

  // Registered pins
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  // Current-digit view of the active buffer
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic       cur_dp;
  logic       in_blank_win;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
`endif
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Prescaler and digit index
  always_comb begin
    pre_wrap  = (pre_q == PreMax);
    frame_end = pre_wrap && (idx_q == IdxMax);
    pre_d     = pre_wrap ? '0 : pre_q + PreW'(1);
    idx_d     = idx_q;
    if (pre_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  assign in_w = '{val: value, blk: blank, dpm: dp_in};

  // Pending/active buffers: new data only reaches the pins at a frame boundary
  always_comb begin
    pend_d       = pend_q;
    act_d        = act_q;
    pend_valid_d = pend_valid_q;
    if (frame_end) begin
      if (load) begin
        act_d        = in_w;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_d        = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_d       = in_w;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib   = act_q.val[4*k +: 4];
        cur_blank = act_q.blk[k];
        cur_dp    = act_q.dpm[k];
      end
    end
  end

  if (BLANK_CYCLES == 0) begin : gen_no_blank
    assign in_blank_win = 1'b0;
  end else begin : gen_blank
    assign in_blank_win = (32'(pre_q) < BLANK_CYCLES);
  end

  // A blanked digit also releases its anode, so the whole slot stays dark
  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
    dp_d  = 1'b1;
    fs_d  = (pre_q == '0) && (idx_q == '0);
    if (!in_blank_win && !cur_blank) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = decode(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_q       <= DispReset;
      act_q        <= DispReset;
      pend_valid_q <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: spec-level reference model checked every cycle, a vector
// table for digit patterns, and directed sequences for tearing, boundary load and reset.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .blank      (blank),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] pat [16];
`ifdef SEG7_HEX_EN
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
            7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
    return pat[n];
  endfunction

  // Reference model: position derived from cycles since reset release
  int          k_cnt = 0;
  int          slot, phase;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_blk = '1, p_blk = '1;
  logic [3:0]  m_dp = '0, p_dp = '0;
  bit          m_pv = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_dp = 1'b1;
  logic        exp_fs = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      k_cnt = 0;
      m_val = '0; m_blk = '1; m_dp = '0;
      p_val = '0; p_blk = '1; p_dp = '0;
      m_pv = 1'b0;
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      slot  = (k_cnt / DIV) % ND;
      phase = k_cnt % DIV;
      exp_fs  = ((k_cnt % FRAME) == 0);
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
      if (phase >= BLK && !m_blk[slot]) begin
        exp_an[slot] = 1'b0;
        exp_seg      = ref_seg(m_val[4*slot +: 4]);
        exp_dp       = ~m_dp[slot];
      end
      if ((k_cnt % FRAME) == FRAME - 1) begin
        if (load) begin
          m_val = value; m_blk = blank; m_dp = dp_in; m_pv = 1'b0;
        end else if (m_pv) begin
          m_val = p_val; m_blk = p_blk; m_dp = p_dp; m_pv = 1'b0;
        end
      end else if (load) begin
        p_val = value; p_blk = blank; p_dp = dp_in; m_pv = 1'b1;
      end
      k_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_seg", 32'(seg), 32'(exp_seg));
    chk("model_an", 32'(an), 32'(exp_an));
    chk("model_dp", 32'(dp), 32'(exp_dp));
    chk("model_frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    value = v; blank = b; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * FRAME && !seen; n++) begin
      tick();
      if (frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_start: got no pulse expected one within %0d cycles", 3 * FRAME);
    end
  endtask

  typedef struct {
    logic [15:0] v;
    logic [3:0]  b;
    logic [3:0]  d;
    int          dig;
    logic [6:0]  s;
    logic [3:0]  a;
    logic        p;
  } vec_t;

  vec_t vecs [10];
  int   cnt;
  bit   dark;

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0100, 0, 7'b0011001, 4'b1110, 1'b1};
    vecs[1] = '{16'h1234, 4'b0000, 4'b0100, 1, 7'b0110000, 4'b1101, 1'b1};
    vecs[2] = '{16'h1234, 4'b0000, 4'b0100, 2, 7'b0100100, 4'b1011, 1'b0};
    vecs[3] = '{16'h1234, 4'b0000, 4'b0100, 3, 7'b1111001, 4'b0111, 1'b1};
    vecs[4] = '{16'h0007, 4'b1110, 4'b1111, 0, 7'b1111000, 4'b1110, 1'b0};
    vecs[5] = '{16'h0007, 4'b1110, 4'b1111, 1, 7'h7F,      4'b1111, 1'b1};
`ifdef SEG7_HEX_EN
    vecs[6] = '{16'hABCD, 4'b0000, 4'b0000, 0, 7'b0100001, 4'b1110, 1'b1};
    vecs[7] = '{16'hABCD, 4'b0000, 4'b0000, 1, 7'b1000110, 4'b1101, 1'b1};
    vecs[8] = '{16'hABCD, 4'b0000, 4'b0000, 2, 7'b0000011, 4'b1011, 1'b1};
    vecs[9] = '{16'hABCD, 4'b0000, 4'b0000, 3, 7'b0001000, 4'b0111, 1'b1};
`else
    vecs[6] = '{16'hABCD, 4'b0000, 4'b0000, 0, 7'h7F, 4'b1110, 1'b1};
    vecs[7] = '{16'hABCD, 4'b0000, 4'b0000, 1, 7'h7F, 4'b1101, 1'b1};
    vecs[8] = '{16'hABCD, 4'b0000, 4'b0000, 2, 7'h7F, 4'b1011, 1'b1};
    vecs[9] = '{16'hABCD, 4'b0000, 4'b0000, 3, 7'h7F, 4'b0111, 1'b1};
`endif

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_frame_start", 32'(frame_start), 32'h0);
    reset = 1'b0;
    tick();
    chk("first_frame_start", 32'(frame_start), 32'h1);
    cnt  = 0;
    dark = 1'b1;
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick();
      cnt++;
      if (an !== 4'hF) dark = 1'b0;
      if (frame_start === 1'b1) break;
    end
    chk("frame_period", 32'(cnt), 32'(FRAME));
    chk("dark_after_reset", 32'(dark), 32'h1);

    // Vector table: each entry loaded, then sampled mid-slot of its digit
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].v, vecs[i].b, vecs[i].d);
      wait_fs();
      repeat (DIV * vecs[i].dig + BLK) tick();
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].s));
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].a));
      chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].p));
    end

    // Tearing: mid-frame load must not alter the rest of the current frame
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_fs();
    repeat (DIV + 3) tick();
    do_load(16'h5678, 4'b0000, 4'b0000);
    repeat (6) tick();
    chk("tear_digit2_an", 32'(an), 32'hB);
    chk("tear_digit2_seg", 32'(seg), 32'(7'b0100100));
    repeat (DIV) tick();
    chk("tear_digit3_seg", 32'(seg), 32'(7'b1111001));
    wait_fs();
    repeat (BLK) tick();
    chk("tear_new_digit0_seg", 32'(seg), 32'(7'b0000000));

    // Load exactly on the boundary cycle shows up in the frame that follows at once
    repeat (FRAME - 2 - BLK) tick();
    do_load(16'h0009, 4'b0000, 4'b0000);
    tick();
    chk("boundary_frame_start", 32'(frame_start), 32'h1);
    repeat (BLK) tick();
    chk("boundary_load_seg", 32'(seg), 32'(7'b0010000));

    // Reset during digit 2 slot with a load pending
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_fs();
    repeat (2 * DIV + 2) tick();
    do_load(16'h5678, 4'b0000, 4'b0000);
    reset = 1'b1;
    tick();
    chk("midreset_seg", 32'(seg), 32'h7F);
    chk("midreset_an", 32'(an), 32'hF);
    chk("midreset_dp", 32'(dp), 32'h1);
    reset = 1'b0;
    dark = 1'b1;
    for (int n = 0; n < FRAME + 8; n++) begin
      tick();
      if (an !== 4'hF || seg !== 7'h7F) dark = 1'b0;
    end
    chk("midreset_discard", 32'(dark), 32'h1);

    // Random loads and occasional resets against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      load = ($urandom_range(9) == 0);
      if (load) begin
        value = 16'($urandom);
        blank = 4'($urandom & $urandom);
        dp_in = 4'($urandom);
      end
      reset = ($urandom_range(399) == 0);
    end
    load  = 1'b0;
    reset = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
